// File: rtl/regfile_preload.sv
// Integer register file with a sequential clear engine after reset, a handshaked
// preload port that yields to WB writes, and a registered debug read port.
module regfile_preload #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [AW-1:0]   io_rs1,
   input  logic [AW-1:0]   io_rs2,
   output logic [XLEN-1:0] io_rs1_out,
   output logic [XLEN-1:0] io_rs2_out,
   input  logic [AW-1:0]   io_rd,
   input  logic [XLEN-1:0] io_wdata,
   input  logic            io_Reg_Write,
   output logic            io_ready,
   input  logic            io_ld_valid,
   output logic            io_ld_ready,
   input  logic [AW-1:0]   io_ld_addr,
   input  logic [XLEN-1:0] io_ld_data,
   input  logic [AW-1:0]   io_dbg_addr,
   output logic [XLEN-1:0] io_dbg_data
);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] dbg_q, dbg_d;

   logic            wen;
   logic [AW-1:0]   waddr;
   logic [XLEN-1:0] wdat;

   function automatic logic is_zero_reg(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   function automatic logic [XLEN-1:0] array_read(input logic [AW-1:0] a);
      return is_zero_reg(a) ? '0 : regs_q[a];
   endfunction

   function automatic logic [XLEN-1:0] port_read(input logic [AW-1:0] a);
      if (state_q != S_RUN)
         return '0;
      if ((BYPASS != 0) && io_Reg_Write && (io_rd == a) && !is_zero_reg(io_rd))
         return io_wdata;
      return array_read(a);
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(NREGS - 1))
               state_d = S_RUN;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign io_ready    = (state_q == S_RUN);
   assign io_ld_ready = (state_q == S_RUN) && !io_Reg_Write;

   // Single array write port: clear engine, then WB, then preload; nothing lands during reset.
   always_comb begin
      wen   = 1'b0;
      waddr = '0;
      wdat  = '0;
      if (!reset) begin
         if (state_q == S_CLEAR) begin
            wen   = 1'b1;
            waddr = cnt_q;
         end else if (io_Reg_Write) begin
            wen   = !is_zero_reg(io_rd);
            waddr = io_rd;
            wdat  = io_wdata;
         end else if (io_ld_valid && io_ld_ready) begin
            wen   = !is_zero_reg(io_ld_addr);
            waddr = io_ld_addr;
            wdat  = io_ld_data;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (wen)
         regs_q[waddr] <= wdat;
   end

   always_comb begin
      io_rs1_out = port_read(io_rs1);
      io_rs2_out = port_read(io_rs2);
      dbg_d      = (state_q == S_RUN) ? array_read(io_dbg_addr) : '0;
   end

   always_ff @(posedge clock) begin
      if (reset)
         dbg_q <= '0;
      else
         dbg_q <= dbg_d;
   end

   assign io_dbg_data = dbg_q;

endmodule

// File: tb/tb_regfile_preload.sv
// Bench for regfile_preload: three instances (default, no-bypass, 64-bit/16-entry
// without hardwired zero) checked against an array-based reference model.
module tb_regfile_preload;

   localparam int NA = 32;
   localparam int NC = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Shared stimulus for the two 32-bit instances
   logic [4:0]  rs1, rs2, rd, lda, dbga;
   logic [31:0] wdata, ldd;
   logic        we, ldv;
   logic [31:0] a_o1, a_o2, a_dbg, b_o1, b_o2, b_dbg;
   logic        a_rdy, a_ldr, b_rdy, b_ldr;

   // Stimulus for the 64-bit instance
   logic [3:0]  c_rs1, c_rs2, c_rd, c_lda, c_dbga;
   logic [63:0] c_wdata, c_ldd;
   logic        c_we, c_ldv;
   logic [63:0] c_o1, c_o2, c_dbg;
   logic        c_rdy, c_ldr;

   regfile_preload #(.XLEN(32), .NREGS(NA), .ZERO_REG(1), .BYPASS(1)) u_a (
      .clock(clk), .reset(rst), .io_rs1(rs1), .io_rs2(rs2), .io_rs1_out(a_o1), .io_rs2_out(a_o2),
      .io_rd(rd), .io_wdata(wdata), .io_Reg_Write(we), .io_ready(a_rdy), .io_ld_valid(ldv),
      .io_ld_ready(a_ldr), .io_ld_addr(lda), .io_ld_data(ldd), .io_dbg_addr(dbga), .io_dbg_data(a_dbg));

   regfile_preload #(.XLEN(32), .NREGS(NA), .ZERO_REG(1), .BYPASS(0)) u_b (
      .clock(clk), .reset(rst), .io_rs1(rs1), .io_rs2(rs2), .io_rs1_out(b_o1), .io_rs2_out(b_o2),
      .io_rd(rd), .io_wdata(wdata), .io_Reg_Write(we), .io_ready(b_rdy), .io_ld_valid(ldv),
      .io_ld_ready(b_ldr), .io_ld_addr(lda), .io_ld_data(ldd), .io_dbg_addr(dbga), .io_dbg_data(b_dbg));

   regfile_preload #(.XLEN(64), .NREGS(NC), .ZERO_REG(0), .BYPASS(1)) u_c (
      .clock(clk), .reset(rst), .io_rs1(c_rs1), .io_rs2(c_rs2), .io_rs1_out(c_o1), .io_rs2_out(c_o2),
      .io_rd(c_rd), .io_wdata(c_wdata), .io_Reg_Write(c_we), .io_ready(c_rdy), .io_ld_valid(c_ldv),
      .io_ld_ready(c_ldr), .io_ld_addr(c_lda), .io_ld_data(c_ldd), .io_dbg_addr(c_dbga), .io_dbg_data(c_dbg));

   // Reference model: contents plus number of clear cycles still outstanding
   logic [31:0] ma [NA];
   logic [63:0] mc [NC];
   int          left_a, left_c;
   logic [31:0] dbg_ea;
   logic [63:0] dbg_ec;
   bit          chk_en;
   int          n_chk = 0;
   int          n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_a(input logic [4:0] a, input bit byp);
      if (left_a > 0) return '0;
      if (byp && we && rd == a && rd != 0) return wdata;
      if (a == 0) return '0;
      return ma[a];
   endfunction

   function automatic logic [63:0] exp_c(input logic [3:0] a);
      if (left_c > 0) return '0;
      if (c_we && c_rd == a) return c_wdata;
      return mc[a];
   endfunction

   task automatic model_edge();
      if (rst) begin
         left_a = NA; left_c = NC; dbg_ea = '0; dbg_ec = '0;
         return;
      end
      if (left_a > 0) begin
         left_a--; dbg_ea = '0;
         if (left_a == 0) foreach (ma[i]) ma[i] = '0;
      end else begin
         dbg_ea = (dbga == 0) ? '0 : ma[dbga];
         if (we) begin
            if (rd != 0) ma[rd] = wdata;
         end else if (ldv && lda != 0) ma[lda] = ldd;
      end
      if (left_c > 0) begin
         left_c--; dbg_ec = '0;
         if (left_c == 0) foreach (mc[i]) mc[i] = '0;
      end else begin
         dbg_ec = mc[c_dbga];
         if (c_we) mc[c_rd] = c_wdata;
         else if (c_ldv) mc[c_lda] = c_ldd;
      end
   endtask

   // Inputs are held from 1 time unit after one edge to the next edge.
   task automatic cycle();
      #2;
      if (chk_en) begin
         check("a_rs1", a_o1, exp_a(rs1, 1));
         check("a_rs2", a_o2, exp_a(rs2, 1));
         check("b_rs1", b_o1, exp_a(rs1, 0));
         check("b_rs2", b_o2, exp_a(rs2, 0));
         check("a_ready", a_rdy, left_a == 0);
         check("b_ready", b_rdy, left_a == 0);
         check("a_ld_ready", a_ldr, left_a == 0 && !we);
         check("c_rs1", c_o1, exp_c(c_rs1));
         check("c_rs2", c_o2, exp_c(c_rs2));
         check("c_ready", c_rdy, left_c == 0);
         check("c_ld_ready", c_ldr, left_c == 0 && !c_we);
      end
      @(posedge clk);
      model_edge();
      #1;
      if (chk_en) begin
         check("a_dbg", a_dbg, dbg_ea);
         check("b_dbg", b_dbg, dbg_ea);
         check("c_dbg", c_dbg, dbg_ec);
      end
   endtask

   task automatic idle();
      rst = 1'b0; we = 1'b0; ldv = 1'b0; c_we = 1'b0; c_ldv = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0, nc = 0;
      while (!a_rdy && n < 100) begin
         if (!c_rdy) nc++;
         n++;
         cycle();
      end
      check({tag, "_lat32"}, 64'(n), 64'd32);
      check({tag, "_lat16"}, 64'(nc), 64'd16);
   endtask

   initial begin
      chk_en = 0;
      idle();
      rs1 = '0; rs2 = '0; rd = '0; lda = '0; dbga = '0; wdata = '0; ldd = '0;
      c_rs1 = '0; c_rs2 = '0; c_rd = '0; c_lda = '0; c_dbga = '0; c_wdata = '0; c_ldd = '0;
      left_a = NA; left_c = NC; dbg_ea = '0; dbg_ec = '0;
      rst = 1'b1;
      cycle();
      chk_en = 1;
      check("rst_ready", a_rdy, 1'b0);
      check("rst_ld_ready", a_ldr, 1'b0);
      check("rst_dbg", a_dbg, 32'd0);
      rst = 1'b0;
      wait_ready("clr");

      for (int i = 0; i < NA; i++) begin
         rs1 = 5'(i); c_rs1 = 4'(i);
         #1 check("sweep_zero", a_o1, 32'd0);
         cycle();
      end

      ldv = 1'b1; lda = 5'd5; ldd = 32'hDEADBEEF;
      cycle();
      ldv = 1'b0; rs1 = 5'd5;
      #1 check("pl_x5", a_o1, 32'hDEADBEEF);
      cycle();
      ldv = 1'b1; lda = 5'd0; ldd = 32'h1234;
      cycle();
      ldv = 1'b0; rs1 = 5'd0;
      #1 check("pl_x0", a_o1, 32'd0);
      cycle();

      ldv = 1'b1; lda = 5'd7; ldd = 32'h77;
      cycle();
      ldv = 1'b0; we = 1'b1; rd = 5'd7; wdata = 32'hA5A5A5A5; rs2 = 5'd7;
      #1 check("byp_on", a_o2, 32'hA5A5A5A5);
      check("byp_off_old", b_o2, 32'h77);
      cycle();
      we = 1'b0;
      #1 check("byp_off_new", b_o2, 32'hA5A5A5A5);
      cycle();

      ldv = 1'b1; lda = 5'd3; ldd = 32'h11; we = 1'b1; rd = 5'd3; wdata = 32'h22; rs1 = 5'd3;
      #1 check("ld_blocked", a_ldr, 1'b0);
      cycle();
      we = 1'b0;
      #1 check("wb_wins", a_o1, 32'h22);
      check("ld_free", a_ldr, 1'b1);
      cycle();
      ldv = 1'b0;
      #1 check("ld_done", a_o1, 32'h11);
      cycle();

      ldv = 1'b1; lda = 5'd9; ldd = 32'h55;
      cycle();
      idle(); rst = 1'b1;
      cycle();
      rst = 1'b0;
      repeat (10) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      wait_ready("reclr");
      rs1 = 5'd9;
      #1 check("x9_cleared", a_o1, 32'd0);
      cycle();

      c_we = 1'b1; c_rd = 4'd0; c_wdata = '1;
      cycle();
      c_we = 1'b0; c_rs1 = 4'd0; c_dbga = 4'd0;
      #1 check("c_x0", c_o1, 64'hFFFF_FFFF_FFFF_FFFF);
      cycle();
      check("c_dbg_x0", c_dbg, 64'hFFFF_FFFF_FFFF_FFFF);

      for (int k = 0; k < 400; k++) begin
         rst   = ($urandom_range(0, 99) == 0);
         we    = 1'($urandom_range(0, 2) == 0);
         ldv   = 1'($urandom_range(0, 1));
         rd    = 5'($urandom_range(0, 31));
         lda   = 5'($urandom_range(0, 31));
         wdata = $urandom; ldd = $urandom;
         rs1   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
         rs2   = ($urandom_range(0, 3) == 0) ? lda : 5'($urandom_range(0, 31));
         dbga  = 5'($urandom_range(0, 31));
         c_we  = 1'($urandom_range(0, 2) == 0);
         c_ldv = 1'($urandom_range(0, 1));
         c_rd  = 4'($urandom_range(0, 15));
         c_lda = 4'($urandom_range(0, 15));
         c_wdata = {$urandom, $urandom}; c_ldd = {$urandom, $urandom};
         c_rs1 = ($urandom_range(0, 3) == 0) ? c_rd : 4'($urandom_range(0, 15));
         c_rs2 = 4'($urandom_range(0, 15));
         c_dbga = 4'($urandom_range(0, 15));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
